// File: rtl/restoring_div_core.sv
// restoring_div_core: sequential restoring divider, one quotient bit per clock; optional RESTORING_DIV_ZERO_CHECK_EN short-cuts divide-by-zero
module restoring_div_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ld_q,
    output logic [WIDTH-1:0] q_data
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef RESTORING_DIV_ZERO_CHECK_EN
    localparam bit ZERO_CHK = 1'b1;
`else
    localparam bit ZERO_CHK = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, a_d, qr_q, qr_d, m_q, quot_q, rem_q;
    logic [WIDTH:0]   a_sh, a_diff;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dbz_q, zero_skip;
    // One restoring step: shift {A,Q} left, trial-subtract M, restore on a negative result.
    // The partial remainder stays below M, so its restored value always fits in WIDTH bits.
    always_comb begin
        a_sh      = {a_q, qr_q[WIDTH-1]};
        a_diff    = a_sh - {1'b0, m_q};
        a_d       = a_diff[WIDTH] ? a_sh[WIDTH-1:0] : a_diff[WIDTH-1:0];
        qr_d      = {qr_q[WIDTH-2:0], ~a_diff[WIDTH]};
        zero_skip = ZERO_CHK && (divisor == '0);
    end
    // Control FSM with registered results; reset discards any in-flight division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= '0;
                    qr_q    <= dividend;
                    m_q     <= divisor;
                    cnt_q   <= CW'(WIDTH);
                    busy_q  <= 1'b1;
                    quot_q  <= zero_skip ? '1 : '0;
                    rem_q   <= zero_skip ? dividend : '0;
                    dbz_q   <= zero_skip;
                    done_q  <= zero_skip;
                    state_q <= zero_skip ? DONE : RUN;
                end
                RUN: begin
                    a_q   <= a_d;
                    qr_q  <= qr_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        quot_q  <= qr_d;
                        rem_q   <= a_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign ld_q        = done_q;
    assign quotient    = quot_q;
    assign q_data      = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_div_core.sv
// tb_restoring_div_core: scoreboard bench for restoring_div_core (WIDTH=4)
module tb_restoring_div_core;
    localparam int W = 4;
`ifdef RESTORING_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         busy, done, div_by_zero, ld_q;
    logic [W-1:0] quotient, remainder, q_data;
    int           cyc = 0, n_cmp = 0, n_bad = 0;
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           t;
    } exp_t;
    exp_t sb[$];
    restoring_div_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .ld_q(ld_q), .q_data(q_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Monitor: pops one expectation per done pulse and checks output coherence every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("ld_q_eq_done", int'(ld_q), int'(done));
            chk("q_data_eq_quotient", int'(q_data), int'(quotient));
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("div_by_zero", int'(div_by_zero), int'(e.z));
                    chk("done_cycle", cyc, e.t);
                    chk("busy_in_done", int'(busy), 1);
                end
            end
        end
    end
    task automatic issue(input logic [W-1:0] dd, dv, q, r, input logic z, input int lat);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{q, r, z, cyc + lat});
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [W-1:0] vec [7][4] = '{
            '{4'd13, 4'd3, 4'd4, 4'd1}, '{4'd15, 4'd1, 4'd15, 4'd0},
            '{4'd7, 4'd9, 4'd0, 4'd7},  '{4'd0, 4'd5, 4'd0, 4'd0},
            '{4'd15, 4'd15, 4'd1, 4'd0}, '{4'd1, 4'd15, 4'd0, 4'd1},
            '{4'd8, 4'd2, 4'd4, 4'd0}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ld_q", int'(ld_q), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_q_data", int'(q_data), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            issue(vec[i][0], vec[i][1], vec[i][2], vec[i][3], 1'b0, W);
            wait_idle();
        end
        issue(4'd9, 4'd0, 4'd15, 4'd9, ZC, ZC ? 0 : W);
        wait_idle();
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{4'd4, 4'd1, 1'b0, cyc + W});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                break;
            end
            dividend = W'($urandom_range(0, 15));
            divisor  = W'($urandom_range(1, 15));
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_not_requeued", int'(busy), 0);
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_done", int'(done), 0);
        chk("midrun_rst_ld_q", int'(ld_q), 0);
        chk("midrun_rst_quotient", int'(quotient), 0);
        chk("midrun_rst_remainder", int'(remainder), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, W);
        wait_idle();
        for (int dd = 0; dd < 16; dd++)
            for (int dv = 1; dv < 16; dv++) begin
                issue(W'(dd), W'(dv), W'(dd / dv), W'(dd % dv), 1'b0, W);
                wait_idle();
            end
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
